// File: rtl/bsg_mem_1rw_march_bist.sv
// March C- BIST initiator for a 1rw bit-mask SRAM wrapper; one op per cycle, read data checked one cycle later.
// Test length 10*els_p op cycles plus CHECK; no backpressure, memory must accept every cycle.
module bsg_mem_1rw_march_bist #(
  parameter int width_p       = 15,
  parameter int els_p         = 64,
  parameter int addr_width_lp = $clog2(els_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     start_i,
  output logic                     mem_v_o,
  output logic                     mem_w_o,
  output logic [addr_width_lp-1:0] mem_addr_o,
  output logic [width_p-1:0]       mem_data_o,
  output logic [width_p-1:0]       mem_w_mask_o,
  input  logic [width_p-1:0]       mem_data_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     pass_o,
  output logic [addr_width_lp-1:0] fail_addr_o,
  output logic [2:0]               fail_element_o
);

  localparam logic [addr_width_lp-1:0] last_addr_lp = addr_width_lp'(els_p - 1);

  typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_e;

  state_e                     state_r, state_n;
  logic [2:0]                 elem_r;
  logic [addr_width_lp-1:0]   addr_r;
  logic                       phase_r;
  logic                       pending_r;
  logic [width_p-1:0]         exp_r;
  logic [addr_width_lp-1:0]   pend_addr_r;
  logic [2:0]                 pend_elem_r;
  logic                       pass_r;
  logic [addr_width_lp-1:0]   fail_addr_r;
  logic [2:0]                 fail_elem_r;

  logic               rw_elem, is_write, down, op_last, addr_end, mismatch, run, accept_start;
  logic [width_p-1:0] wpat, rpat;

  always_comb begin
    rw_elem  = (elem_r >= 3'd1) && (elem_r <= 3'd4);
    is_write = (elem_r == 3'd0) || (rw_elem && phase_r);
    down     = (elem_r == 3'd3) || (elem_r == 3'd4);
    wpat     = ((elem_r == 3'd1) || (elem_r == 3'd3)) ? '1 : '0;
    rpat     = ((elem_r == 3'd2) || (elem_r == 3'd4)) ? '1 : '0;
    // The write half of a read-write element (or any single-op element) finishes the address.
    op_last  = !rw_elem || phase_r;
    addr_end = down ? (addr_r == '0) : (addr_r == last_addr_lp);
    mismatch = pending_r && (mem_data_i != exp_r);
    run      = (state_r == RUN);
    accept_start = start_i && ((state_r == IDLE) || (state_r == DONE));
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) state_r <= IDLE;
    else         state_r <= state_n;
  end

  always_comb begin
    state_n        = state_r;
    mem_v_o        = 1'b0;
    mem_w_o        = 1'b0;
    mem_addr_o     = '0;
    mem_data_o     = '0;
    mem_w_mask_o   = '0;
    busy_o         = 1'b0;
    done_o         = 1'b0;
    pass_o         = pass_r;
    fail_addr_o    = fail_addr_r;
    fail_element_o = fail_elem_r;
    case (state_r)
      IDLE: if (start_i) state_n = RUN;
      RUN: begin
        busy_o       = 1'b1;
        mem_v_o      = 1'b1;
        mem_w_o      = is_write;
        mem_addr_o   = addr_r;
        mem_data_o   = is_write ? wpat : rpat;
        // Mask is only meaningful with mem_v_o; held low so the port is quiet outside a run.
        mem_w_mask_o = '1;
        if (mismatch)
          state_n = DONE;
        else if (op_last && addr_end && (elem_r == 3'd5))
          state_n = CHECK;
      end
      CHECK: begin
        busy_o  = 1'b1;
        state_n = DONE;
      end
      DONE: begin
        done_o = 1'b1;
        if (start_i) state_n = RUN;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      elem_r      <= '0;
      addr_r      <= '0;
      phase_r     <= 1'b0;
      pending_r   <= 1'b0;
      exp_r       <= '0;
      pend_addr_r <= '0;
      pend_elem_r <= '0;
      pass_r      <= 1'b0;
      fail_addr_r <= '0;
      fail_elem_r <= '0;
    end else if (accept_start) begin
      elem_r      <= '0;
      addr_r      <= '0;
      phase_r     <= 1'b0;
      pending_r   <= 1'b0;
      pass_r      <= 1'b0;
      fail_addr_r <= '0;
      fail_elem_r <= '0;
    end else if (run) begin
      pending_r   <= !is_write;
      exp_r       <= rpat;
      pend_addr_r <= addr_r;
      pend_elem_r <= elem_r;
      if (rw_elem) phase_r <= !phase_r;
      if (op_last) begin
        if (addr_end) begin
          elem_r <= elem_r + 3'd1;
          // Elements 3 and 4 walk downward from the top address.
          addr_r <= ((elem_r == 3'd2) || (elem_r == 3'd3)) ? last_addr_lp : '0;
        end else begin
          addr_r <= down ? addr_r - 1'b1 : addr_r + 1'b1;
        end
      end
      if (mismatch) begin
        fail_addr_r <= pend_addr_r;
        fail_elem_r <= pend_elem_r;
      end
    end else if (state_r == CHECK) begin
      pending_r <= 1'b0;
      if (mismatch) begin
        fail_addr_r <= pend_addr_r;
        fail_elem_r <= pend_elem_r;
      end else begin
        pass_r <= 1'b1;
      end
    end else begin
      pending_r <= 1'b0;
    end
  end

endmodule
